mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath: Moore FSM that steps each instruction

---
 rtl/mips_ctrl_pkg.sv | 79 +++++++
 rtl/mips_ctrl_outdec.sv | 83 ++++++++
 rtl/mips_multicycle_ctrl.sv | 124 ++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle controller: 4-bit state
// encodings, opcode constants, ALU/mux select encodings, the control-word
// struct and the DECODE dispatch function. Shared with ALU control and datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC    = 4'd3,
    S_ALUWB   = 4'd4,
    S_MEMADR  = 4'd5,
    S_MEMRD   = 4'd6,
    S_MEMWB   = 4'd7,
    S_MEMWR   = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_JAL     = 4'd13,
    S_ILLEGAL = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_IMMLOG = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // State entered after DECODE for a given opcode.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:                 return S_EXEC;
      OP_LW, OP_SW:             return S_MEMADR;
      OP_ADDI, OP_ANDI, OP_ORI: return S_IMMEXEC;
      OP_BEQ:                   return S_BRANCH;
      OP_J:                     return S_JUMP;
      OP_JAL:                   return S_JAL;
      default:                  return S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control-word decode for the multi-cycle controller.
// Ports:
//   state     in  current FSM state
//   imm_logic in  registered "andi/ori" flag selecting the imm-logical ALU op
//   ctrl      out full datapath control word
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   imm_logic,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_IMMEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_logic ? ALU_IMMLOG : ALU_ADD;
      end
      S_IMMWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_ILLEGAL: ctrl.illegal_op = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: Moore FSM stepping each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, plus retired-instruction counter.
// Optional feature macro: MEM_HANDSHAKE_EN -- FETCH/MEMRD/MEMWR wait for
// mem_ready, and pc_write/ir_write in FETCH fire only in the ready cycle.
// Ports: clk, rst_n (async active-low), opcode (IR[31:26]), mem_ready,
//   datapath enables/selects (pc_write ... pc_source), illegal_op pulse,
//   state_o (debug state), instr_count (COUNT_W bits, wraps).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               link,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [3:0]         state_o,
  output logic [COUNT_W-1:0] instr_count
);

  state_t             state_q, state_d;
  logic               imm_logic_q, imm_logic_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               mem_done;
  ctrl_t              ctrl_raw, ctrl;

`ifdef MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    imm_logic_d = imm_logic_q;
    count_d     = count_q;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        state_d = decode_next(opcode);
        // Latch the andi/ori distinction so IMMEXEC stays a function of state.
        imm_logic_d = (opcode == OP_ANDI) || (opcode == OP_ORI);
      end
      S_EXEC:    state_d = S_ALUWB;
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_done) state_d = S_MEMWB;
      S_MEMWR:   if (mem_done) state_d = S_FETCH;
      S_IMMEXEC: state_d = S_IMMWB;
      S_ALUWB, S_MEMWB, S_IMMWB, S_BRANCH, S_JUMP, S_JAL, S_ILLEGAL:
                 state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
    // Retire on entering FETCH from a completing state; IDLE and ILLEGAL excluded.
    if ((state_d == S_FETCH) &&
        (state_q inside {S_ALUWB, S_MEMWB, S_MEMWR, S_IMMWB, S_BRANCH, S_JUMP, S_JAL}))
      count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      imm_logic_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      imm_logic_q <= imm_logic_d;
      count_q     <= count_d;
    end
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .imm_logic (imm_logic_q),
    .ctrl      (ctrl_raw)
  );

  always_comb begin
    ctrl = ctrl_raw;
`ifdef MEM_HANDSHAKE_EN
    // While the fetch is stalled, the PC and IR must not load.
    if ((state_q == S_FETCH) && !mem_ready) begin
      ctrl.pc_write = 1'b0;
      ctrl.ir_write = 1'b0;
    end
`endif
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign link          = ctrl.link;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign state_o       = state_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table of instructions with
// expected cycle counts and final-cycle control words, a per-phase reference
// model, randomized instruction streams, and reset/handshake corner cases.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b1;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, link, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state_o;
  logic [31:0] instr_count;

  // Narrow-counter instance used to observe wraparound.
  logic [17:0] cw2;
  logic [3:0]  state2;
  logic [2:0]  count_small;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .link(link), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
    .state_o(state_o), .instr_count(instr_count)
  );

  mips_multicycle_ctrl #(.COUNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(cw2[17]), .pc_write_cond(cw2[16]), .i_or_d(cw2[15]),
    .mem_read(cw2[14]), .mem_write(cw2[13]), .ir_write(cw2[12]),
    .reg_dst(cw2[11]), .mem_to_reg(cw2[10]), .reg_write(cw2[9]),
    .link(cw2[8]), .alu_src_a(cw2[7]), .alu_src_b(cw2[6:5]),
    .alu_op(cw2[4:3]), .pc_source(cw2[2:1]), .illegal_op(cw2[0]),
    .state_o(state2), .instr_count(count_small)
  );

  logic [17:0] act;
  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, link, alu_src_a,
                alu_src_b, alu_op, pc_source, illegal_op};

  int total = 0;
  int bad = 0;
  int model_count = 0;

  task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  function automatic logic [17:0] w(input logic pcw, input logic pcwc, input logic iord,
                                    input logic mr, input logic mw, input logic irw,
                                    input logic rd, input logic m2r, input logic rw,
                                    input logic lk, input logic a, input logic [1:0] b,
                                    input logic [1:0] op, input logic [1:0] ps,
                                    input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, lk, a, b, op, ps, ill};
  endfunction

  // Control word required in each named phase of an instruction.
  function automatic logic [17:0] cw_of(input string ph);
    case (ph)
      "IDLE":      return '0;
      "FETCH":     return w(1,0,0,1,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0);
      "DECODE":    return w(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
      "EXEC":      return w(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
      "ALUWB":     return w(0,0,0,0,0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0);
      "MEMADR":    return w(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
      "MEMRD":     return w(0,0,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
      "MEMWB":     return w(0,0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0);
      "MEMWR":     return w(0,0,1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
      "IMMEXEC":   return w(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
      "IMMEXEC_L": return w(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0);
      "IMMWB":     return w(0,0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0);
      "BRANCH":    return w(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
      "JUMP":      return w(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
      "JAL":       return w(1,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b10,0);
      "ILLEGAL":   return w(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1);
      default:     return '1;
    endcase
  endfunction

  // Phase k (0-based) of the instruction with opcode op; "" once it has ended.
  function automatic string phase_of(input logic [5:0] op, input int k);
    string seq[$];
    seq = '{"FETCH", "DECODE"};
    case (op)
      6'b000000: seq = {seq, "EXEC", "ALUWB"};
      6'b100011: seq = {seq, "MEMADR", "MEMRD", "MEMWB"};
      6'b101011: seq = {seq, "MEMADR", "MEMWR"};
      6'b001000: seq = {seq, "IMMEXEC", "IMMWB"};
      6'b001100, 6'b001101: seq = {seq, "IMMEXEC_L", "IMMWB"};
      6'b000100: seq.push_back("BRANCH");
      6'b000010: seq.push_back("JUMP");
      6'b000011: seq.push_back("JAL");
      default:   seq.push_back("ILLEGAL");
    endcase
    if (k < seq.size()) return seq[k];
    return "";
  endfunction

  function automatic int ncyc(input logic [5:0] op);
    int n = 0;
    while (phase_of(op, n) != "") n++;
    return n;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100,
                      6'b001101, 6'b000100, 6'b000010, 6'b000011};
  endfunction

  // Entered at a negedge in FETCH; leaves at the negedge of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input int n, input string tag,
                           output logic [17:0] last_act);
    opcode = op;
    last_act = '0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s op=%b cyc%0d ctrl", tag, op, k), 64'(act), 64'(cw_of(phase_of(op, k))));
      check($sformatf("%s cyc%0d rd_wr_mutex", tag, k), 64'(mem_read & mem_write), 64'd0);
      check($sformatf("%s cyc%0d rw_pcw", tag, k), 64'(reg_write & pc_write & ~link), 64'd0);
      last_act = act;
`ifndef MEM_HANDSHAKE_EN
      mem_ready = 1'($urandom_range(0, 1));
`endif
      @(negedge clk);
    end
    if (is_legal(op)) model_count++;
    check($sformatf("%s op=%b count", tag, op), 64'(instr_count), 64'(model_count));
    check($sformatf("%s op=%b count3", tag, op), 64'(count_small), 64'(model_count % 8));
    check($sformatf("%s op=%b next_fetch", tag, op), 64'(state_o), 64'(S_FETCH));
  endtask

  typedef struct {
    logic [5:0]  op;
    int          cycles;
    logic [17:0] last_cw;
  } vec_t;

  vec_t        tbl[10];
  logic [5:0]  legal_ops[9];
  logic [17:0] last;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{6'b000000, 4, w(0,0,0,0,0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0)};
    tbl[1] = '{6'b100011, 5, w(0,0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0)};
    tbl[2] = '{6'b101011, 4, w(0,0,1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0)};
    tbl[3] = '{6'b001000, 4, w(0,0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0)};
    tbl[4] = '{6'b001100, 4, w(0,0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0)};
    tbl[5] = '{6'b001101, 4, w(0,0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0)};
    tbl[6] = '{6'b000100, 3, w(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0)};
    tbl[7] = '{6'b000010, 3, w(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0)};
    tbl[8] = '{6'b000011, 3, w(1,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b10,0)};
    tbl[9] = '{6'b111111, 3, w(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1)};
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100,
                  6'b001101, 6'b000100, 6'b000010, 6'b000011};

    // Reset held for three cycles.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ctrl", 64'(act), 64'd0);
    check("reset state", 64'(state_o), 64'(S_IDLE));
    check("reset count", 64'(instr_count), 64'd0);
    rst_n = 1'b1;
    #1 check("idle after release", 64'(state_o), 64'(S_IDLE));
    check("idle ctrl", 64'(act), 64'(cw_of("IDLE")));
    @(negedge clk);
    check("first fetch", 64'(state_o), 64'(S_FETCH));

    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].op, tbl[i].cycles, "tbl", last);
      check($sformatf("tbl op=%b last_cycle_ctrl", tbl[i].op), 64'(last), 64'(tbl[i].last_cw));
    end

    for (int i = 0; i < 50; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
      else op = legal_ops[$urandom_range(0, 8)];
      run_instr(op, ncyc(op), "rnd", last);
    end
    mem_ready = 1'b1;

`ifdef MEM_HANDSHAKE_EN
    // Fetch stalled four cycles.
    opcode = 6'b000000;
    mem_ready = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hs fetch hold%0d state", k), 64'(state_o), 64'(S_FETCH));
      check($sformatf("hs fetch hold%0d pc_write", k), 64'(pc_write), 64'd0);
      check($sformatf("hs fetch hold%0d ir_write", k), 64'(ir_write), 64'd0);
      check($sformatf("hs fetch hold%0d mem_read", k), 64'(mem_read), 64'd1);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1 check("hs fetch ready pc_write", 64'(pc_write), 64'd1);
    @(negedge clk);
    check("hs decode after ready", 64'(state_o), 64'(S_DECODE));
    repeat (3) @(negedge clk);
    model_count++;
    check("hs count", 64'(instr_count), 64'(model_count));
    // lw stalled in MEMRD.
    opcode = 6'b100011;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hs memrd hold%0d", k), 64'(act), 64'(cw_of("MEMRD")));
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("hs memwb after ready", 64'(act), 64'(cw_of("MEMWB")));
    @(negedge clk);
    model_count++;
    check("hs lw count", 64'(instr_count), 64'(model_count));
`endif

    // Asynchronous reset in the middle of a load, while in MEMRD.
    opcode = 6'b100011;
    repeat (3) @(negedge clk);
    check("mid memrd ctrl", 64'(act), 64'(cw_of("MEMRD")));
    #2 rst_n = 1'b0;
    #1;
    check("async reset ctrl", 64'(act), 64'd0);
    check("async reset state", 64'(state_o), 64'(S_IDLE));
    check("async reset count", 64'(instr_count), 64'd0);
    check("async reset count3", 64'(count_small), 64'd0);
    model_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("refetch after reset", 64'(state_o), 64'(S_FETCH));
    run_instr(6'b000011, 3, "post", last);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
